// File: rtl/ysyx_25020037_icache.sv
// ysyx_25020037_icache: direct-mapped read-only I-cache, AXI-lite word-by-word refill, fence.i, hit/miss counters
//  clk, rst (async, active-high)
//  req_valid/req_ready/req_addr        IFU fetch request
//  resp_valid/resp_ready/resp_inst/resp_err  fetch response (err => refill saw rresp != 0)
//  fence_i                             invalidate all lines once idle
//  araddr/arvalid/arready, rdata/rresp/rvalid/rready  AXI-lite read port
//  hit_cnt/miss_cnt                    free-running lookup counters
module ysyx_25020037_icache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  input  logic        fence_i,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);
  localparam int WB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = 30 - WB - IB;
  typedef enum logic [2:0] {IDLE, LOOKUP, AR, R, RESP} state_t;
  state_t state, state_n;
  logic [31:2] a_q;
  logic [LINES-1:0] valid;
  logic [TB-1:0] tags [LINES];
  logic [31:0] data [LINES][WORDS];
  logic [WB-1:0] cnt, word;
  logic [IB-1:0] idx;
  logic [TB-1:0] tag;
  logic fence_pend, accept, hit, beat, ok, last, unused_lsb;
  assign unused_lsb = ^req_addr[1:0];
  assign word = a_q[WB+1:2];
  assign idx = a_q[WB+IB+1:WB+2];
  assign tag = a_q[31:WB+IB+2];
  assign hit = valid[idx] && tags[idx] == tag;
  assign beat = rvalid && rready;
  assign ok = rresp == 2'b00;
  assign last = cnt == WB'(WORDS - 1);
  assign req_ready = state == IDLE && !fence_pend;
  // a fence pulse in the accept cycle wins over the request
  assign accept = req_ready && req_valid && !fence_i;
  assign resp_valid = state == RESP;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? LOOKUP : IDLE;
      LOOKUP:  state_n = hit ? RESP : AR;
      AR:      state_n = arready ? R : AR;
      R:       state_n = !beat ? R : (!ok || last) ? RESP : AR;
      RESP:    state_n = resp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      valid <= '0;
      cnt <= '0;
      araddr <= '0;
      arvalid <= 1'b0;
      rready <= 1'b0;
      resp_inst <= '0;
      resp_err <= 1'b0;
      hit_cnt <= '0;
      miss_cnt <= '0;
      fence_pend <= 1'b0;
    end else begin
      // pending fence survives until the clear done in IDLE
      fence_pend <= fence_i || (fence_pend && state != IDLE);
      case (state)
        IDLE: begin
          if (fence_pend) valid <= '0;
          else if (accept) a_q <= req_addr[31:2];
        end
        LOOKUP: begin
          if (hit) begin
            resp_inst <= data[idx][word];
            hit_cnt <= hit_cnt + 32'd1;
          end else begin
            miss_cnt <= miss_cnt + 32'd1;
            valid[idx] <= 1'b0;
            cnt <= '0;
            araddr <= {a_q[31:WB+2], {(WB+2){1'b0}}};
            arvalid <= 1'b1;
          end
        end
        AR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready <= 1'b1;
          end
        end
        R: begin
          if (beat) begin
            rready <= 1'b0;
            if (!ok) begin
              resp_err <= 1'b1;
              resp_inst <= '0;
            end else begin
              if (cnt == word) resp_inst <= rdata;
              if (last) valid[idx] <= 1'b1;
              else begin
                cnt <= cnt + 1'b1;
                araddr <= araddr + 32'd4;
                arvalid <= 1'b1;
              end
            end
          end
        end
        RESP: if (resp_ready) resp_err <= 1'b0;
        default: ;
      endcase
    end
  // tag/data storage carries no reset so it can map onto RAM
  always_ff @(posedge clk)
    if (state == R && beat && ok) begin
      data[idx][cnt] <= rdata;
      if (last) tags[idx] <= tag;
    end
endmodule

// File: tb/tb_ysyx_25020037_icache.sv
// tb_ysyx_25020037_icache: randomized bench for the I-cache against a line-level reference model
module tb_ysyx_25020037_icache;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, resp_valid, resp_ready = 0, resp_err, fence_i = 0;
  logic [31:0] req_addr = 0, resp_inst, araddr, rdata, hit_cnt, miss_cnt;
  logic arvalid, arready, rvalid, rready;
  logic [1:0] rresp;
  int n_chk = 0, n_pass = 0;
  int ar_delay = 0, r_delay = 0, err_beat = -1;
  logic [31:0] ar_q[$];
  bit mv[16];
  logic [31:0] ml[16];
  int hits = 0, misses = 0;
  ysyx_25020037_icache dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_inst(resp_inst), .resp_err(resp_err),
    .fence_i(fence_i), .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata),
    .rresp(rresp), .rvalid(rvalid), .rready(rready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h1000 + ((a - 32'h8000_0000) >> 2);
  endfunction
  // AXI-lite slave: random AR/R latencies, optional error on a chosen beat
  initial begin
    logic [31:0] a;
    bit hs, er;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk);
      arready = 0;
      check("ar_r_excl", 32'(arvalid && rready), 0);
      if (rst || !arvalid) continue;
      a = araddr;
      for (int i = 0; i < ar_delay; i++) begin
        @(negedge clk);
        check("ar_hold_addr", araddr, a);
        check("ar_hold_valid", 32'(arvalid), 1);
      end
      arready = 1;
      ar_q.push_back(a);
      @(negedge clk);
      arready = 0;
      repeat (r_delay) @(negedge clk);
      er = err_beat == int'(a[3:2]);
      rvalid = 1; rdata = mem(a); rresp = er ? 2'b10 : 2'b00;
      hs = rready && !rst;
      @(negedge clk);
      rvalid = 0; rresp = 0; rdata = 0;
      if (hs && !rst && (er || a[3:2] == 2'd3)) check("miss_lat", 32'(resp_valid), 1);
    end
  end
  task automatic fetch(input logic [31:0] addr, input int ard, input int rd, input int rrd,
                       input int eb, input int fat);
    logic [31:0] base, ei;
    int idx, n, nb;
    bit hit, ee, fenced;
    base = {addr[31:4], 4'h0};
    idx = int'(addr[7:4]);
    hit = mv[idx] && ml[idx] == base;
    ee = !hit && eb >= 0;
    ei = ee ? 32'h0 : mem({addr[31:2], 2'b00});
    nb = hit ? 0 : ee ? eb + 1 : 4;
    fenced = 0;
    ar_delay = ard; r_delay = rd; err_beat = hit ? -1 : eb;
    ar_q.delete();
    @(negedge clk);
    req_valid = 1; req_addr = addr;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = 0; req_addr = $urandom;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
      fence_i = n == fat;
      if (fence_i) fenced = 1;
    end
    fence_i = 0;
    check("resp_valid", 32'(resp_valid), 1);
    if (hit) begin hits++; check("hit_lat", n, 2); end
    else misses++;
    repeat (rrd) begin
      check("hold_valid", 32'(resp_valid), 1);
      check("hold_inst", resp_inst, ei);
      @(negedge clk);
    end
    resp_ready = 1;
    check("inst", resp_inst, ei);
    check("err", 32'(resp_err), 32'(ee));
    @(posedge clk);
    #1 resp_ready = 0;
    check("ar_count", ar_q.size(), nb);
    foreach (ar_q[i]) check("ar_addr", ar_q[i], base + 32'(4 * i));
    if (!hit) begin mv[idx] = !ee; ml[idx] = base; end
    if (fenced) begin
      @(negedge clk);
      check("fence_block", 32'(req_ready), 0);
      check("resp_drop", 32'(resp_valid), 0);
      @(negedge clk);
      check("fence_done", 32'(req_ready), 1);
      mv = '{default: 0};
    end
    check("hit_cnt", hit_cnt, hits);
    check("miss_cnt", miss_cnt, misses);
  endtask
  task automatic idle_fence();
    @(negedge clk);
    fence_i = 1;
    @(negedge clk);
    fence_i = 0;
    check("idle_fence_block", 32'(req_ready), 0);
    @(negedge clk);
    check("idle_fence_done", 32'(req_ready), 1);
    mv = '{default: 0};
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_arvalid"}, 32'(arvalid), 0);
    check({tag, "_rready"}, 32'(rready), 0);
    check({tag, "_araddr"}, araddr, 0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 0);
    check({tag, "_resp_err"}, 32'(resp_err), 0);
    check({tag, "_resp_inst"}, resp_inst, 0);
    check({tag, "_hit_cnt"}, hit_cnt, 0);
    check({tag, "_miss_cnt"}, miss_cnt, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    mv = '{default: 0};
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 0;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 1);
    fetch(32'h8000_0008, 0, 0, 0, -1, -1);
    fetch(32'h8000_000C, 0, 0, 0, -1, -1);
    fetch(32'h8000_0100, 1, 1, 0, -1, -1);
    fetch(32'h8000_0000, 0, 0, 1, -1, -1);
    fetch(32'h8000_0044, 0, 0, 0, 1, -1);
    fetch(32'h8000_0044, 0, 0, 0, -1, -1);
    fetch(32'h8000_0048, 0, 0, 0, -1, -1);
    fetch(32'h8000_0080, 0, 1, 0, -1, 2);
    fetch(32'h8000_0084, 0, 0, 0, -1, -1);
    fetch(32'h8000_0010, 5, 0, 3, -1, -1);
    idle_fence();
    fetch(32'h8000_0010, 0, 0, 0, -1, -1);
    ar_delay = 0; r_delay = 6; err_beat = -1;
    @(negedge clk);
    req_valid = 1; req_addr = 32'h9000_0000;
    @(posedge clk);
    #1 req_valid = 0;
    n = 0;
    while (!rready && n < 50) begin @(negedge clk); n++; end
    check("rready_up", 32'(rready), 1);
    @(negedge clk);
    rst = 1;
    #1 check_zero("mid_r_reset");
    repeat (3) @(negedge clk);
    rst = 0;
    mv = '{default: 0}; hits = 0; misses = 0;
    repeat (12) @(negedge clk);
    ar_q.delete();
    check("post_reset_req_ready", 32'(req_ready), 1);
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 15) == 0) idle_fence();
      fetch(32'h8000_0000 + ($urandom_range(0, 255) << 2), $urandom_range(0, 2), $urandom_range(0, 2),
            $urandom_range(0, 2), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1,
            ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : -1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
